bram_be_dp: RTL and testbench

BRAM_BE_DP -- requirements
Module: bram_be_dp

---
 rtl/bram_be_dp.sv | 149 ++++++++++++++
 tb/tb_bram_be_dp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_be_dp.sv
// True dual-port block RAM with byte-lane write enables, selectable same-port
// read-during-write behaviour, optional output register and a post-reset zero-fill sweep.
module bram_be_dp #(
  parameter int WADDR        = 10,
  parameter int WDATA        = 32,
  parameter int RD_MODE      = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic               pi_clk,
  input  logic               pi_rst,
  input  logic               pi_ena,
  input  logic               pi_enb,
  input  logic [WDATA/8-1:0] pi_wea,
  input  logic [WDATA/8-1:0] pi_web,
  input  logic [WADDR-1:0]   pi_addra,
  input  logic [WADDR-1:0]   pi_addrb,
  input  logic [WDATA-1:0]   pi_dia,
  input  logic [WDATA-1:0]   pi_dib,
  output logic [WDATA-1:0]   po_doa,
  output logic [WDATA-1:0]   po_dob,
  output logic               po_vala,
  output logic               po_valb,
  output logic               po_ready
);

  localparam int NB    = WDATA / 8;
  localparam int DEPTH = 2 ** WADDR;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WADDR-1:0] r_cnt;
  logic [WDATA-1:0] r_mem [DEPTH];

  logic             w_ready;
  logic             w_acc_a, w_acc_b;
  logic             w_wr_a, w_wr_b;
  logic             w_rv_a, w_rv_b;
  logic [WDATA-1:0] w_rd_a, w_rd_b;
  logic [WDATA-1:0] r_doa_s1, r_dob_s1;
  logic             r_vala_s1, r_valb_s1;

  function automatic logic [WDATA-1:0] merge_lanes(input logic [WDATA-1:0] old_word,
                                                   input logic [WDATA-1:0] new_word,
                                                   input logic [NB-1:0]    we);
    logic [WDATA-1:0] m;
    m = old_word;
    for (int i = 0; i < NB; i++) begin
      if (we[i]) m[8*i +: 8] = new_word[8*i +: 8];
    end
    return m;
  endfunction

  assign w_ready = (r_state == S_READY);
  assign po_ready = w_ready;

  // Accesses are dropped while clearing and while reset is held, so reset never touches the array.
  assign w_acc_a = pi_ena && w_ready && !pi_rst;
  assign w_acc_b = pi_enb && w_ready && !pi_rst;
  assign w_wr_a  = w_acc_a && (|pi_wea);
  assign w_wr_b  = w_acc_b && (|pi_web);
  assign w_rv_a  = w_acc_a && !(w_wr_a && RD_MODE == 2);
  assign w_rv_b  = w_acc_b && !(w_wr_b && RD_MODE == 2);

  always_comb begin
    w_rd_a = r_mem[pi_addra];
    w_rd_b = r_mem[pi_addrb];
    if (RD_MODE == 1 && w_wr_a) w_rd_a = merge_lanes(r_mem[pi_addra], pi_dia, pi_wea);
    if (RD_MODE == 1 && w_wr_b) w_rd_b = merge_lanes(r_mem[pi_addrb], pi_dib, pi_web);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_CLEAR && (&r_cnt)) w_state_nxt = S_READY;
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      r_state <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_READY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_cnt <= r_cnt + 1'b1;
    end
  end

  // NOTE: the array has no reset branch; zeroing is done by the CLEAR sweep so it still maps to block RAM.
  always_ff @(posedge pi_clk) begin
    if (r_state == S_CLEAR) begin
      if (!pi_rst) r_mem[r_cnt] <= '0;
    end else begin
      // NOTE: port A's lanes are assigned after port B's, so the later non-blocking update makes A win.
      for (int i = 0; i < NB; i++) begin
        if (w_wr_b && pi_web[i]) r_mem[pi_addrb][8*i +: 8] <= pi_dib[8*i +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (w_wr_a && pi_wea[i]) r_mem[pi_addra][8*i +: 8] <= pi_dia[8*i +: 8];
      end
    end
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      r_doa_s1  <= '0;
      r_dob_s1  <= '0;
      r_vala_s1 <= 1'b0;
      r_valb_s1 <= 1'b0;
    end else begin
      r_vala_s1 <= w_rv_a;
      r_valb_s1 <= w_rv_b;
      if (w_rv_a) r_doa_s1 <= w_rd_a;
      if (w_rv_b) r_dob_s1 <= w_rd_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [WDATA-1:0] r_doa_s2, r_dob_s2;
      logic             r_vala_s2, r_valb_s2;

      always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
          r_doa_s2  <= '0;
          r_dob_s2  <= '0;
          r_vala_s2 <= 1'b0;
          r_valb_s2 <= 1'b0;
        end else begin
          r_vala_s2 <= r_vala_s1;
          r_valb_s2 <= r_valb_s1;
          if (r_vala_s1) r_doa_s2 <= r_doa_s1;
          if (r_valb_s1) r_dob_s2 <= r_dob_s1;
        end
      end

      assign po_doa  = r_doa_s2;
      assign po_dob  = r_dob_s2;
      assign po_vala = r_vala_s2;
      assign po_valb = r_valb_s2;
    end else begin : g_noreg
      assign po_doa  = r_doa_s1;
      assign po_dob  = r_dob_s1;
      assign po_vala = r_vala_s1;
      assign po_valb = r_valb_s1;
    end
  endgenerate

endmodule

// File: tb/tb_bram_be_dp.sv
// Directed bench for bram_be_dp: default instance, a write-first/registered-output
// instance and a no-change instance without clear, all driven from shared stimulus.
module tb_bram_be_dp;

  logic        clk;
  logic        rst;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [9:0]  addra, addrb;
  logic [31:0] dia, dib;

  logic [31:0] doa0, dob0, doa1, dob1, doa2, dob2;
  logic        vala0, valb0, vala1, valb1, vala2, valb2;
  logic        rdy0, rdy1, rdy2;

  int n_checks = 0;
  int n_errors = 0;

  bram_be_dp dut0 (
    .pi_clk(clk), .pi_rst(rst), .pi_ena(ena), .pi_enb(enb), .pi_wea(wea), .pi_web(web),
    .pi_addra(addra), .pi_addrb(addrb), .pi_dia(dia), .pi_dib(dib),
    .po_doa(doa0), .po_dob(dob0), .po_vala(vala0), .po_valb(valb0), .po_ready(rdy0)
  );

  bram_be_dp #(.WADDR(4), .RD_MODE(1), .OUT_REG(1)) dut_wf (
    .pi_clk(clk), .pi_rst(rst), .pi_ena(ena), .pi_enb(enb), .pi_wea(wea), .pi_web(web),
    .pi_addra(addra[3:0]), .pi_addrb(addrb[3:0]), .pi_dia(dia), .pi_dib(dib),
    .po_doa(doa1), .po_dob(dob1), .po_vala(vala1), .po_valb(valb1), .po_ready(rdy1)
  );

  bram_be_dp #(.WADDR(4), .RD_MODE(2), .CLEAR_ON_RST(0)) dut_nc (
    .pi_clk(clk), .pi_rst(rst), .pi_ena(ena), .pi_enb(enb), .pi_wea(wea), .pi_web(web),
    .pi_addra(addra[3:0]), .pi_addrb(addrb[3:0]), .pi_dia(dia), .pi_dib(dib),
    .po_doa(doa2), .po_dob(dob2), .po_vala(vala2), .po_valb(valb2), .po_ready(rdy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus at a falling edge; returns at the next falling edge with ports idle.
  task automatic drive(input logic ea, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db);
    ena = ea; wea = wa; addra = aa; dia = da;
    enb = eb; web = wb; addrb = ab; dib = db;
    @(negedge clk);
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  // Release reset and count cycles until each clearing instance reports ready; enables are held meanwhile.
  task automatic release_and_clear(input string tag, input logic hold_read);
    int n0, n1, val_seen;
    n0 = 0; n1 = 0; val_seen = 0;
    rst = 1'b0;
    ena = hold_read; wea = '0; addra = 10'd7;
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      if (vala0 || valb0) val_seen++;
      if (!hold_read && (vala1 || valb1)) val_seen++;
      if (rdy1 && n1 == 0) n1 = n;
      if (rdy0) begin n0 = n; break; end
    end
    ena = 1'b0;
    n_checks++; if (n0 != 1024) begin n_errors++; $display("FAIL %s_ready_cycles: got %0d want %0d", tag, n0, 1024); end
    n_checks++; if (n1 != 16) begin n_errors++; $display("FAIL %s_ready_cycles_small: got %0d want %0d", tag, n1, 16); end
    n_checks++; if (val_seen != 0) begin n_errors++; $display("FAIL %s_val_while_clearing: got %0d pulses want %0d", tag, val_seen, 0); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (doa0 !== 32'h0) begin n_errors++; $display("FAIL reset_doa: got %h want %h", doa0, 32'h0); end
    n_checks++; if (dob0 !== 32'h0) begin n_errors++; $display("FAIL reset_dob: got %h want %h", dob0, 32'h0); end
    n_checks++; if (vala0 !== 1'b0 || valb0 !== 1'b0) begin n_errors++; $display("FAIL reset_val: got %b%b want 00", vala0, valb0); end
    n_checks++; if (rdy0 !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", rdy0); end
    n_checks++; if (rdy1 !== 1'b0) begin n_errors++; $display("FAIL reset_ready_wf: got %b want 0", rdy1); end
    n_checks++; if (rdy2 !== 1'b1) begin n_errors++; $display("FAIL reset_ready_noclear: got %b want 1", rdy2); end
    release_and_clear("clear", 1'b1);
    idle(); idle();
  endtask

  task automatic test_defaults();
    drive(1'b1, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd1023, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'h0) begin n_errors++; $display("FAIL defaults_a0: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'h0); end
    n_checks++; if (valb0 !== 1'b1 || dob0 !== 32'h0) begin n_errors++; $display("FAIL defaults_b1023: got val=%b do=%h want val=1 do=%h", valb0, dob0, 32'h0); end
    drive(1'b1, 4'h0, 10'd517, 32'h0, 1'b1, 4'h0, 10'd300, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'h0) begin n_errors++; $display("FAIL defaults_a517: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'h0); end
    idle();
    n_checks++; if (vala0 !== 1'b0) begin n_errors++; $display("FAIL defaults_val_drop: got %b want 0", vala0); end
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'h0 || valb1 !== 1'b1) begin n_errors++; $display("FAIL defaults_wf: got val=%b%b do=%h want val=11 do=%h", vala1, valb1, doa1, 32'h0); end
    idle();
  endtask

  task automatic test_byte_en();
    drive(1'b1, 4'hF, 10'd5, 32'hAABBCCDD, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'h0) begin n_errors++; $display("FAIL be_w1_readfirst: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'h0); end
    n_checks++; if (vala1 !== 1'b0) begin n_errors++; $display("FAIL be_w1_wf_latency: got val=%b want 0", vala1); end
    n_checks++; if (vala2 !== 1'b0) begin n_errors++; $display("FAIL be_w1_nochange_val: got %b want 0", vala2); end
    drive(1'b1, 4'h5, 10'd5, 32'h11223344, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'hAABBCCDD) begin n_errors++; $display("FAIL be_w2_readfirst: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'hAABBCCDD); end
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'hAABBCCDD) begin n_errors++; $display("FAIL be_w1_writefirst: got val=%b do=%h want val=1 do=%h", vala1, doa1, 32'hAABBCCDD); end
    drive(1'b0, 4'hF, 10'd5, 32'hFFFFFFFF, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (vala0 !== 1'b0 || doa0 !== 32'hAABBCCDD) begin n_errors++; $display("FAIL be_hold: got val=%b do=%h want val=0 do=%h", vala0, doa0, 32'hAABBCCDD); end
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'hAA22CC44) begin n_errors++; $display("FAIL be_w2_writefirst: got val=%b do=%h want val=1 do=%h", vala1, doa1, 32'hAA22CC44); end
    drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 4'h0, 10'd5, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'hAA22CC44) begin n_errors++; $display("FAIL be_read_a: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'hAA22CC44); end
    n_checks++; if (valb0 !== 1'b1 || dob0 !== 32'hAA22CC44) begin n_errors++; $display("FAIL be_read_b: got val=%b do=%h want val=1 do=%h", valb0, dob0, 32'hAA22CC44); end
    n_checks++; if (vala2 !== 1'b1 || doa2 !== 32'hAA22CC44) begin n_errors++; $display("FAIL be_read_nochange: got val=%b do=%h want val=1 do=%h", vala2, doa2, 32'hAA22CC44); end
    idle();
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'hAA22CC44 || dob1 !== 32'hAA22CC44) begin n_errors++; $display("FAIL be_read_wf: got val=%b do=%h/%h want val=1 do=%h", vala1, doa1, dob1, 32'hAA22CC44); end
    n_checks++; if (vala0 !== 1'b0 || doa0 !== 32'hAA22CC44) begin n_errors++; $display("FAIL be_hold_after_read: got val=%b do=%h want val=0 do=%h", vala0, doa0, 32'hAA22CC44); end
    idle();
  endtask

  task automatic test_collision();
    drive(1'b1, 4'h1, 10'd9, 32'h000000FF, 1'b1, 4'hF, 10'd9, 32'h12345678);
    n_checks++; if (vala0 !== 1'b1 || valb0 !== 1'b1 || doa0 !== 32'h0 || dob0 !== 32'h0) begin n_errors++; $display("FAIL coll_prewrite: got val=%b%b do=%h/%h want val=11 do=0/0", vala0, valb0, doa0, dob0); end
    drive(1'b1, 4'h0, 10'd9, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
    n_checks++; if (doa0 !== 32'h123456FF || dob0 !== 32'h123456FF) begin n_errors++; $display("FAIL coll_result: got %h/%h want %h", doa0, dob0, 32'h123456FF); end
    n_checks++; if (vala2 !== 1'b1 || doa2 !== 32'h123456FF) begin n_errors++; $display("FAIL coll_result_nochange: got val=%b do=%h want val=1 do=%h", vala2, doa2, 32'h123456FF); end
    n_checks++; if (doa1 !== 32'h000000FF || dob1 !== 32'h12345678) begin n_errors++; $display("FAIL coll_writefirst: got %h/%h want %h/%h", doa1, dob1, 32'h000000FF, 32'h12345678); end
    idle();
    n_checks++; if (doa1 !== 32'h123456FF || dob1 !== 32'h123456FF) begin n_errors++; $display("FAIL coll_result_wf: got %h/%h want %h", doa1, dob1, 32'h123456FF); end
    idle();
  endtask

  task automatic test_cross_read();
    drive(1'b1, 4'hF, 10'd9, 32'hCAFEF00D, 1'b1, 4'h0, 10'd9, 32'h0);
    n_checks++; if (valb0 !== 1'b1 || dob0 !== 32'h123456FF) begin n_errors++; $display("FAIL cross_b_old: got val=%b do=%h want val=1 do=%h", valb0, dob0, 32'h123456FF); end
    n_checks++; if (vala2 !== 1'b0 || valb2 !== 1'b1 || dob2 !== 32'h123456FF) begin n_errors++; $display("FAIL cross_nochange: got val=%b%b do=%h want val=01 do=%h", vala2, valb2, dob2, 32'h123456FF); end
    drive(1'b1, 4'h0, 10'd9, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (doa0 !== 32'hCAFEF00D || doa2 !== 32'hCAFEF00D) begin n_errors++; $display("FAIL cross_new: got %h/%h want %h", doa0, doa2, 32'hCAFEF00D); end
    n_checks++; if (valb1 !== 1'b1 || dob1 !== 32'h123456FF) begin n_errors++; $display("FAIL cross_b_old_wf: got val=%b do=%h want val=1 do=%h", valb1, dob1, 32'h123456FF); end
    idle(); idle();
  endtask

  task automatic test_modes();
    drive(1'b1, 4'hF, 10'd3, 32'h1, 1'b0, 4'h0, 10'd0, 32'h0);
    drive(1'b1, 4'hF, 10'd3, 32'h2, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'h1) begin n_errors++; $display("FAIL mode_readfirst: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'h1); end
    n_checks++; if (vala2 !== 1'b0 || doa2 !== 32'hCAFEF00D) begin n_errors++; $display("FAIL mode_nochange: got val=%b do=%h want val=0 do=%h", vala2, doa2, 32'hCAFEF00D); end
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'h1) begin n_errors++; $display("FAIL mode_writefirst_w1: got val=%b do=%h want val=1 do=%h", vala1, doa1, 32'h1); end
    idle();
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'h2) begin n_errors++; $display("FAIL mode_writefirst_w2: got val=%b do=%h want val=1 do=%h", vala1, doa1, 32'h2); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (vala1 !== 1'b0) begin n_errors++; $display("FAIL b2b_a_early: got val=%b want 0", vala1); end
    drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0);
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'hAA22CC44 || valb1 !== 1'b0) begin n_errors++; $display("FAIL b2b_a_pulse: got val=%b%b do=%h want val=10 do=%h", vala1, valb1, doa1, 32'hAA22CC44); end
    n_checks++; if (valb0 !== 1'b1 || dob0 !== 32'hCAFEF00D || vala0 !== 1'b0) begin n_errors++; $display("FAIL b2b_b_noreg: got val=%b%b do=%h want val=01 do=%h", vala0, valb0, dob0, 32'hCAFEF00D); end
    idle();
    n_checks++; if (vala1 !== 1'b0 || doa1 !== 32'hAA22CC44) begin n_errors++; $display("FAIL b2b_a_hold: got val=%b do=%h want val=0 do=%h", vala1, doa1, 32'hAA22CC44); end
    n_checks++; if (valb1 !== 1'b1 || dob1 !== 32'hCAFEF00D) begin n_errors++; $display("FAIL b2b_b_pulse: got val=%b do=%h want val=1 do=%h", valb1, dob1, 32'hCAFEF00D); end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int pulses;
    pulses = 0;
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    repeat (300) @(negedge clk);
    drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    if (vala0 || vala1) pulses++;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (vala0 || vala1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL midclr_flush: got %0d pulses want %0d", pulses, 0); end
    n_checks++; if (doa0 !== 32'h0 || doa1 !== 32'h0) begin n_errors++; $display("FAIL midclr_reset_do: got %h/%h want 0/0", doa0, doa1); end
    n_checks++; if (rdy0 !== 1'b0 || rdy2 !== 1'b1) begin n_errors++; $display("FAIL midclr_reset_ready: got %b/%b want 0/1", rdy0, rdy2); end
    release_and_clear("midclr", 1'b0);
    idle();
    drive(1'b1, 4'h0, 10'd5, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0);
    n_checks++; if (vala0 !== 1'b1 || doa0 !== 32'h0) begin n_errors++; $display("FAIL midclr_cleared: got val=%b do=%h want val=1 do=%h", vala0, doa0, 32'h0); end
    n_checks++; if (vala2 !== 1'b1 || doa2 !== 32'hAA22CC44) begin n_errors++; $display("FAIL midclr_contents_kept: got val=%b do=%h want val=1 do=%h", vala2, doa2, 32'hAA22CC44); end
    idle();
    n_checks++; if (vala1 !== 1'b1 || doa1 !== 32'h0) begin n_errors++; $display("FAIL midclr_cleared_wf: got val=%b do=%h want val=1 do=%h", vala1, doa1, 32'h0); end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    addra = '0; addrb = '0; dia = '0; dib = '0;
    test_reset();
    test_defaults();
    test_byte_en();
    test_collision();
    test_cross_read();
    test_modes();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
